// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALUOp classes
// and the RV32I opcode field values (inst[6:2]) it understands.
package multicycle_control_unit_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RFUNC = 2'b10;
  localparam logic [1:0] ALUOP_IFUNC = 2'b11;

  localparam logic [4:0] OPCODE_Arith_R = 5'b01100;
  localparam logic [4:0] OPCODE_Arith_I = 5'b00100;
  localparam logic [4:0] OPCODE_Load    = 5'b00000;
  localparam logic [4:0] OPCODE_Store   = 5'b01000;
  localparam logic [4:0] OPCODE_Branch  = 5'b11000;

  function automatic logic is_supported(input logic [4:0] op);
    return (op == OPCODE_Arith_R) || (op == OPCODE_Arith_I) || (op == OPCODE_Load) ||
           (op == OPCODE_Store)   || (op == OPCODE_Branch);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Bounded-wait counter for memory handshakes; expire is high on the last
// permitted waiting cycle (count == TIMEOUT-1).
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter bit EN      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (clr)        r_cnt <= '0;
    else if (inc && EN)  r_cnt <= r_cnt + 1'b1;
  end

  assign expire = EN && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer FETCH/DECODE/EXEC/MEM/WB for the RV32I subset, with a
// memory valid/ready handshake, bus timeout and illegal-opcode trap.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W   = 5,
  parameter int ALUOP_W    = 2,
  parameter int TIMEOUT    = 16,
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] inst,
  input  logic                stall,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal_inst,
  output logic                bus_error,
  output logic [2:0]          state_o
);

  logic [2:0]          r_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic                r_bus_cause;
  logic [2:0]          w_nxt;
  logic                w_expire;
  logic                w_clr;
  logic                w_inc;
  logic                w_is_load;
  logic                w_is_store;

  assign w_is_load  = (r_opcode == OPCODE_Load);
  assign w_is_store = (r_opcode == OPCODE_Store);

  // Clearing on every state change covers entry into both FETCH and MEM.
  assign w_clr = !stall && (w_nxt != r_state);
  assign w_inc = mem_req && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .EN(TIMEOUT_EN)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .inc    (w_inc),
    .expire (w_expire)
  );

  always_comb begin
    w_nxt = r_state;
    if (!stall) begin
      case (r_state)
        S_FETCH:  if (mem_ready) w_nxt = S_DECODE;
                  else if (w_expire) w_nxt = S_TRAP;
        S_DECODE: w_nxt = is_supported(inst) ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (r_opcode == OPCODE_Arith_R || r_opcode == OPCODE_Arith_I) w_nxt = S_WB;
          else if (w_is_load || w_is_store)                             w_nxt = S_MEM;
          else                                                          w_nxt = S_FETCH;
        end
        S_MEM:    if (mem_ready) w_nxt = w_is_load ? S_WB : S_FETCH;
                  else if (w_expire) w_nxt = S_TRAP;
        default:  w_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_opcode    <= '0;
      r_bus_cause <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_DECODE && !stall) r_opcode <= inst;
      if (!stall && w_nxt == S_TRAP)     r_bus_cause <= (r_state != S_DECODE);
    end
  end

  // Outputs are held low throughout reset, even though the state already reads FETCH.
  always_comb begin
    mem_req      = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    alu_op       = '0;
    illegal_inst = 1'b0;
    bus_error    = 1'b0;
    state_o      = rst_n ? r_state : 3'd0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = !stall;
          mem_read = !stall;
          ir_write = mem_ready && !stall;
          pc_write = mem_ready && !stall;
        end
        S_EXEC: begin
          if (r_opcode == OPCODE_Arith_R) begin
            alu_op = ALUOP_W'(ALUOP_RFUNC);
          end else if (r_opcode == OPCODE_Arith_I) begin
            alu_src = 1'b1;
            alu_op  = ALUOP_W'(ALUOP_IFUNC);
          end else if (w_is_load || w_is_store) begin
            alu_src = 1'b1;
            alu_op  = ALUOP_W'(ALUOP_ADD);
          end else if (r_opcode == OPCODE_Branch) begin
            alu_op = ALUOP_W'(ALUOP_SUB);
            branch = !stall;
          end
        end
        S_MEM: begin
          mem_req   = !stall;
          i_or_d    = 1'b1;
          mem_read  = w_is_load && !stall;
          mem_write = w_is_store && !stall;
        end
        S_WB: begin
          reg_write  = !stall;
          mem_to_reg = w_is_load;
        end
        S_TRAP: begin
          illegal_inst = !r_bus_cause && !stall;
          bus_error    = r_bus_cause && !stall;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench: per-instruction expected cycle traces built from the sequencing rules,
// compared every cycle against all DUT outputs; directed then random instructions.
module tb_multicycle_control_unit;
  localparam int TO = 4;
  localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CBR = 4, CILL = 5;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

  logic clk = 1'b0, rst_n = 1'b1, stall = 1'b0, mem_ready = 1'b0;
  logic [4:0] inst = '0;
  logic mem_req, i_or_d, ir_write, pc_write, branch, mem_read, mem_write;
  logic mem_to_reg, alu_src, reg_write, illegal_inst, bus_error;
  logic [1:0] alu_op;
  logic [2:0] state_o;
  logic [16:0] obs;

  int n_tests = 0, n_fail = 0;

  typedef struct { logic [2:0] st; logic rdy; logic bus; } step_t;
  step_t q[$];

  multicycle_control_unit #(.OPCODE_W(5), .ALUOP_W(2), .TIMEOUT(TO), .TIMEOUT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .stall(stall), .mem_ready(mem_ready),
    .mem_req(mem_req), .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .illegal_inst(illegal_inst), .bus_error(bus_error), .state_o(state_o));

  always #5 clk = ~clk;

  assign obs = {mem_req, i_or_d, ir_write, pc_write, branch, mem_read, mem_write,
                mem_to_reg, alu_src, reg_write, alu_op, illegal_inst, bus_error, state_o};

  function automatic logic [16:0] exp_vec(logic [2:0] st, int cls, logic rdy, logic bus);
    logic req = 0, iod = 0, irw = 0, pcw = 0, br = 0, rd = 0, wr = 0, m2r = 0, src = 0, rw = 0;
    logic ill = 0, be = 0;
    logic [1:0] op = 2'b00;
    case (st)
      F: begin req = 1; rd = 1; irw = rdy; pcw = rdy; end
      E: case (cls)
           CR:      op = 2'b10;
           CI:      begin op = 2'b11; src = 1; end
           CLD, CST: begin op = 2'b00; src = 1; end
           CBR:     begin op = 2'b01; br = 1; end
           default: ;
         endcase
      M: begin req = 1; iod = 1; rd = (cls == CLD); wr = (cls == CST); end
      W: begin rw = 1; m2r = (cls == CLD); end
      T: begin ill = !bus; be = bus; end
      default: ;
    endcase
    return {req, iod, irw, pcw, br, rd, wr, m2r, src, rw, op, ill, be, st};
  endfunction

  function automatic logic [4:0] op_of(int cls);
    logic [4:0] o;
    case (cls)
      CR: return 5'b01100;
      CI: return 5'b00100;
      CLD: return 5'b00000;
      CST: return 5'b01000;
      CBR: return 5'b11000;
      default: begin
        o = 5'($urandom);
        while (o inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000}) o = 5'($urandom);
        return o;
      end
    endcase
  endfunction

  task automatic push(logic [2:0] st, logic rdy, logic bus);
    step_t s;
    s.st = st; s.rdy = rdy; s.bus = bus;
    q.push_back(s);
  endtask

  // Waiting phase: fw not-ready cycles, then either the ready cycle or a bus trap.
  task automatic wait_phase(logic [2:0] st, int fw, output logic timed_out);
    for (int k = 0; k < fw && k < TO; k++) push(st, 1'b0, 1'b0);
    timed_out = (fw >= TO);
    if (timed_out) push(T, 1'($urandom), 1'b1);
    else           push(st, 1'b1, 1'b0);
  endtask

  task automatic build(int cls, int fw, int mw);
    logic to;
    q.delete();
    wait_phase(F, fw, to);
    if (to) return;
    push(D, 1'($urandom), 1'b0);
    if (cls == CILL) begin push(T, 1'($urandom), 1'b0); return; end
    push(E, 1'($urandom), 1'b0);
    if (cls == CBR) return;
    if (cls == CR || cls == CI) begin push(W, 1'($urandom), 1'b0); return; end
    wait_phase(M, mw, to);
    if (to) return;
    if (cls == CLD) push(W, 1'($urandom), 1'b0);
  endtask

  task automatic chk(string tag, logic [16:0] got, logic [16:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after n cycles.
  task automatic run(string tag, int cls, logic [4:0] op, int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      inst = op;
      #2;
      chk(tag, obs, exp_vec(q[i].st, cls, q[i].rdy, q[i].bus));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_inst(string tag, int cls, int fw, int mw);
    build(cls, fw, mw);
    run(tag, cls, op_of(cls), q.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    #2;
    chk("rst_outs", obs, 17'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk("reset_state", obs, 17'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_inst("r_type", CR, 0, 0);
    do_inst("load_wait3", CLD, 0, 3);
    do_inst("store", CST, 0, 0);
    do_inst("branch", CBR, 0, 0);
    do_inst("i_type", CI, 1, 0);
    build(CILL, 0, 0);
    run("illegal", CILL, 5'b11111, q.size());
    do_inst("store_mem_timeout", CST, 2, TO);

    do_reset();
    do_inst("fetch_timeout", CR, TO, 0);

    // stall in FETCH: requests drop and ready is ignored
    stall = 1'b1; mem_ready = 1'b1; inst = 5'b01100;
    for (int i = 0; i < 2; i++) begin
      #2 chk("stall_fetch", obs, 17'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    build(CR, 0, 0);
    run("stall_pre_wb", CR, 5'b01100, 3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      #2 chk("stall_wb", obs, {14'd0, W});
      @(posedge clk); #1;
    end
    stall = 1'b0;
    #2 chk("wb_after_stall", obs, exp_vec(W, CR, 1'b0, 1'b0));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2 chk("fetch_after_wb", obs, exp_vec(F, CR, 1'b0, 1'b0));
    @(posedge clk); #1;

    // asynchronous reset in the middle of a load's memory wait
    build(CLD, 0, TO - 1);
    run("pre_mid_rst", CLD, 5'b00000, 4);
    mem_ready = 1'b0;
    #1 chk("mem_before_rst", obs, exp_vec(M, CLD, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 chk("rst_mid_mem", obs, 17'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2 chk("fetch_after_rst", obs, exp_vec(F, CLD, 1'b0, 1'b0));
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      int cls, fw, mw;
      cls = $urandom_range(0, 5);
      fw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
      do_inst("rnd", cls, fw, mw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle control decoder: a parametrised Moore FSM that sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK for the RV32I subset (R-type, I-type ALU, load, store, branch).
- Drives datapath enables and the ALUOp code for the existing ALU control.
- Uses a valid/ready handshake to a shared instruction/data memory with a bounded-wait timeout.
- Flags illegal opcodes and bus timeouts to the core's trap logic.

Parameters:
- OPCODE_W, 5, opcode field width (inst[6:2]).
- ALUOP_W, 2, width of alu_op output.
- TIMEOUT, 16, max cycles waiting on mem_ready before bus_error (≥2).
- TIMEOUT_EN, 1, 1 = timeout counter active; 0 = wait indefinitely.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  OPCODE_W  opcode field from the instruction register (valid from DECODE onward).
- stall  in  1  global freeze; FSM holds state and all write enables are forced to 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- i_or_d  out  1  address select (0 = PC, 1 = ALU result).
- ir_write  out  1  latch the fetched word into IR.
- pc_write  out  1  PC <= PC+4.
- branch  out  1  conditional PC update from the branch unit.
- mem_read  out  1  read request qualifier.
- mem_write  out  1  write request qualifier.
- mem_to_reg  out  1  writeback source select (1 = memory data).
- alu_src  out  1  ALU B operand select (1 = immediate).
- reg_write  out  1  register file write enable.
- alu_op  out  ALUOP_W  ALU control class (00 add, 01 sub/compare, 10 R-func, 11 I-func).
- illegal_inst  out  1  one-cycle pulse on an unsupported opcode.
- bus_error  out  1  one-cycle pulse on a memory timeout.
- state_o  out  3  current state encoding, for debug and coverage.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, latched opcode=0, timeout counter=0. Every output is 0 except mem_req=1 and mem_read=1 once reset is released. While rst_n=0, all outputs are 0.
- States (3-bit, in shared package): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: mem_req=1, mem_read=1, i_or_d=0.
  - Stays in FETCH until mem_ready=1.
  - In the mem_ready cycle, ir_write=1 and pc_write=1, and the next state is DECODE.
- DECODE: latch inst into the opcode register. All enables are 0.
  - Supported opcode -> EXEC.
  - Unsupported opcode -> TRAP.
- EXEC: alu_op and alu_src by class.
  - R-type: alu_src=0, alu_op=10 -> WB.
  - I-type ALU: alu_src=1, alu_op=11 -> WB.
  - Load/store: alu_src=1, alu_op=00 -> MEM.
  - Branch: alu_src=0, alu_op=01, branch=1 for exactly this one cycle -> FETCH.
  - Branch has no reg_write.
- MEM: mem_req=1, i_or_d=1.
  - Load: mem_read=1.
  - Store: mem_write=1.
  - Held until mem_ready.
  - Load -> WB on ready; store -> FETCH on ready.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for loads, 0 otherwise -> FETCH.
- TRAP: illegal_inst=1 (or bus_error=1 if the entry cause was a timeout) for one cycle -> FETCH. No register or memory write occurs.
- Minimum latency with mem_ready tied high:
  - R/I: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Timeout (TIMEOUT_EN=1):
  - The counter clears on entering FETCH or MEM and increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT-1 with mem_ready still 0, the next state is TRAP with the cause set to bus.
  - mem_ready=1 in that same cycle wins: the access completes and there is no error.
- stall=1:
  - State, opcode register and counter hold.
  - ir_write, pc_write, reg_write, mem_write and branch are forced to 0.
  - mem_req and mem_read also drop to 0; mem_ready is ignored while stalled.
  - The timeout counter does not advance.
- Simultaneous events: rst_n dominates everything; stall dominates mem_ready.
- Outputs are purely a function of state, latched opcode and stall (Moore), except the ir_write/pc_write qualification by mem_ready in FETCH.

Decomposition:
- Shared package/defines:
  - state encodings;
  - ALUOp class constants;
  - the existing OPCODE_Arith_R, OPCODE_Arith_I, OPCODE_Load, OPCODE_Store and OPCODE_Branch values.
- One sub-module, mem_wait_timer: counter with clear, enable and expire output, parametrised by TIMEOUT.

Test Plan:
- Reset then mem_ready=1, inst=01100 (R) -> state sequence 0,1,2,4,0; reg_write=1 only in the WB cycle; alu_op=10 in EXEC.
- inst=00000 (load) with mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles; then WB with mem_to_reg=1; total 8 cycles.
- inst=01000 (store), mem_ready=1 -> mem_write=1 for one cycle; reg_write never asserted; back to FETCH after 4 cycles.
- inst=11000 (branch) -> branch=1 for exactly one cycle, alu_op=01; returns to FETCH after 3 cycles.
- inst=11111 (illegal) -> TRAP with illegal_inst pulse of 1 cycle; no write enables asserted.
- TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error pulse at cycle 5 after reset release.
- Mid-MEM rst_n low -> all outputs 0 immediately, FETCH on release.
- stall asserted in WB for 3 cycles -> reg_write stays 0 and WB is held; reg_write=1 on the cycle after stall falls.
